// File: rtl/regfile_scoreboard_16x16.sv
// regfile_scoreboard_16x16: 16 x 16-bit register file, two combinational read
// ports, one synchronous write port and a per-register busy scoreboard that
// raises a decode-stage stall on in-flight source operands.
// R0 is hardwired to zero and can never be marked busy.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports and let a busy source that is being written not stall.
module regfile_scoreboard_16x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  input  logic [3:0]  DstReg,
  input  logic        WriteReg,
  input  logic [15:0] DstData,
  input  logic [3:0]  IssueReg,
  input  logic        IssueValid,
  output logic [15:0] SrcData1,
  output logic [15:0] SrcData2,
  output logic        Stall,
  output logic [15:0] BusyVec
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic [DEPTH-1:0]  rd1_sel;
  logic [DEPTH-1:0]  rd2_sel;
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  iss_sel;
  logic [DATA_W-1:0] mem [1:DEPTH-1];
  logic [DATA_W-1:0] word [DEPTH];
  logic [DATA_W-1:0] rd1_word;
  logic [DATA_W-1:0] rd2_word;
  logic [DEPTH-1:0]  busy_q;
  logic              byp1;
  logic              byp2;

  // One-hot wordline decoders; issue never selects R0
  always_comb begin
    rd1_sel = DEPTH'(1) << SrcReg1;
    rd2_sel = DEPTH'(1) << SrcReg2;
    wr_sel  = WriteReg ? (DEPTH'(1) << DstReg) : '0;
    iss_sel = IssueValid ? ((DEPTH'(1) << IssueReg) & ~DEPTH'(1)) : '0;
  end

  // Storage for R1..R15; a write to R0 has no register to land in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (wr_sel[ADDR_W'(i)]) begin
          mem[ADDR_W'(i)] <= DstData;
        end
      end
    end
  end

  // Full word view with R0 tied to zero
  always_comb begin
    word[0] = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      word[ADDR_W'(i)] = mem[ADDR_W'(i)];
    end
  end

  // AND-OR read muxes driven by the one-hot read wordlines
  always_comb begin
    rd1_word = '0;
    rd2_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rd1_word = rd1_word | (word[ADDR_W'(i)] & {DATA_W{rd1_sel[ADDR_W'(i)]}});
      rd2_word = rd2_word | (word[ADDR_W'(i)] & {DATA_W{rd2_sel[ADDR_W'(i)]}});
    end
  end

  // Scoreboard: write clears, issue sets, set wins on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~wr_sel) | iss_sel;
    end
  end

  // Same-cycle write-to-read forwarding match (never for R0)
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    byp1 = WriteReg && (DstReg == SrcReg1) && (SrcReg1 != 4'd0);
    byp2 = WriteReg && (DstReg == SrcReg2) && (SrcReg2 != 4'd0);
`else
    byp1 = 1'b0;
    byp2 = 1'b0;
`endif
  end

  // Read data, stall and busy vector outputs
  always_comb begin
    SrcData1 = byp1 ? DstData : rd1_word;
    SrcData2 = byp2 ? DstData : rd2_word;
    Stall    = ((|(busy_q & rd1_sel)) & ~byp1) |
               ((|(busy_q & rd2_sel)) & ~byp2);
    BusyVec  = busy_q;
  end

endmodule

// File: tb/tb_regfile_scoreboard_16x16.sv
// Directed self-checking bench for regfile_scoreboard_16x16.
// Expectations follow REGFILE_BYPASS_EN when the same macro is defined here.
module tb_regfile_scoreboard_16x16;

  logic        clk;
  logic        rst;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [3:0]  IssueReg;
  logic        IssueValid;
  logic [15:0] SrcData1;
  logic [15:0] SrcData2;
  logic        Stall;
  logic [15:0] BusyVec;

  int tests;
  int fails;
  bit byp;

  regfile_scoreboard_16x16 dut (
    .clk        (clk),
    .rst        (rst),
    .SrcReg1    (SrcReg1),
    .SrcReg2    (SrcReg2),
    .DstReg     (DstReg),
    .WriteReg   (WriteReg),
    .DstData    (DstData),
    .IssueReg   (IssueReg),
    .IssueValid (IssueValid),
    .SrcData1   (SrcData1),
    .SrcData2   (SrcData2),
    .Stall      (Stall),
    .BusyVec    (BusyVec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, landing away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    tests = 0;
    fails = 0;
    rst = 1'b1;
    SrcReg1 = '0; SrcReg2 = '0; DstReg = '0; WriteReg = 1'b0;
    DstData = '0; IssueReg = '0; IssueValid = 1'b0;
    #12;
    rst = 1'b0;
    #1;

    // Reset state: every register reads zero on both ports
    for (int i = 0; i < 16; i++) begin
      SrcReg1 = 4'(i);
      SrcReg2 = 4'(15 - i);
      #1;
      chk("rst_rd1", SrcData1, 16'h0000);
      chk("rst_rd2", SrcData2, 16'h0000);
    end
    chk("rst_stall", {15'd0, Stall}, 16'h0000);
    chk("rst_busy", BusyVec, 16'h0000);

    // Write R5 = BEEF, read on both ports next cycle
    WriteReg = 1'b1; DstReg = 4'd5; DstData = 16'hBEEF;
    step();
    WriteReg = 1'b0; SrcReg1 = 4'd5; SrcReg2 = 4'd5;
    #1;
    chk("r5_rd1", SrcData1, 16'hBEEF);
    chk("r5_rd2", SrcData2, 16'hBEEF);

    // Write to R0 is discarded and never forwarded
    WriteReg = 1'b1; DstReg = 4'd0; DstData = 16'h1234; SrcReg1 = 4'd0;
    #1;
    chk("r0_same_cycle", SrcData1, 16'h0000);
    step();
    WriteReg = 1'b0;
    #1;
    chk("r0_after", SrcData1, 16'h0000);
    chk("r5_intact", SrcData2, 16'hBEEF);

    // Give R7 a known old value, then overwrite while reading it
    WriteReg = 1'b1; DstReg = 4'd7; DstData = 16'h1111;
    step();
    DstData = 16'hA5A5; SrcReg1 = 4'd7;
    #1;
    chk("r7_same_cycle", SrcData1, byp ? 16'hA5A5 : 16'h1111);
    step();
    WriteReg = 1'b0;
    #1;
    chk("r7_next_cycle", SrcData1, 16'hA5A5);

    // Issue R3, then a source on R3 stalls until its write
    IssueValid = 1'b1; IssueReg = 4'd3; SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    step();
    IssueValid = 1'b0;
    #1;
    chk("busy_r3", BusyVec, 16'h0008);
    chk("no_stall_r0", {15'd0, Stall}, 16'h0000);
    SrcReg2 = 4'd3;
    #1;
    chk("stall_r3", {15'd0, Stall}, 16'h0001);
    WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h0333;
    #1;
    chk("stall_r3_wr", {15'd0, Stall}, byp ? 16'h0000 : 16'h0001);
    chk("r3_wr_data", SrcData2, byp ? 16'h0333 : 16'h0000);
    step();
    WriteReg = 1'b0;
    #1;
    chk("stall_r3_clr", {15'd0, Stall}, 16'h0000);
    chk("busy_r3_clr", BusyVec, 16'h0000);
    chk("r3_data", SrcData2, 16'h0333);

    // Issue and write R9 on the same edge: set wins
    IssueValid = 1'b1; IssueReg = 4'd9;
    WriteReg = 1'b1; DstReg = 4'd9; DstData = 16'h9999;
    SrcReg1 = 4'd0; SrcReg2 = 4'd0;
    step();
    IssueValid = 1'b0; WriteReg = 1'b0; SrcReg1 = 4'd9;
    #1;
    chk("busy_r9_collide", BusyVec, 16'h0200);
    chk("r9_data", SrcData1, 16'h9999);
    chk("stall_r9", {15'd0, Stall}, 16'h0001);

    // Issue to R0 never sets busy[0]
    IssueValid = 1'b1; IssueReg = 4'd0; SrcReg1 = 4'd0;
    step();
    IssueValid = 1'b0;
    #1;
    chk("busy_r0_issue", BusyVec, 16'h0200);
    chk("stall_r0_issue", {15'd0, Stall}, 16'h0000);

    // Write R12 = FFFF, then issue R12
    WriteReg = 1'b1; DstReg = 4'd12; DstData = 16'hFFFF;
    step();
    WriteReg = 1'b0; IssueValid = 1'b1; IssueReg = 4'd12;
    step();
    IssueValid = 1'b0; SrcReg1 = 4'd12; SrcReg2 = 4'd5;
    #1;
    chk("r12_data", SrcData1, 16'hFFFF);
    chk("busy_r12", BusyVec, 16'h1200);
    chk("stall_r12", {15'd0, Stall}, 16'h0001);

    // Asynchronous reset between edges clears everything at once
    #1;
    rst = 1'b1;
    #1;
    chk("arst_r12", SrcData1, 16'h0000);
    chk("arst_r5", SrcData2, 16'h0000);
    chk("arst_busy", BusyVec, 16'h0000);
    chk("arst_stall", {15'd0, Stall}, 16'h0000);

    // Write and issue presented while reset is held are discarded
    WriteReg = 1'b1; DstReg = 4'd12; DstData = 16'hABCD;
    IssueValid = 1'b1; IssueReg = 4'd12;
    step();
    WriteReg = 1'b0; IssueValid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_drop_wr", SrcData1, 16'h0000);
    chk("rst_drop_iss", BusyVec, 16'h0000);
    step();
    chk("post_rst_r12", SrcData1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
